uart_rx_data40: RTL
===================

Name: uart_rx_data40

Overview:
- Receive side of the team's 5-byte UART link.
- Deserialises 8N1 bytes from the serial line and assembles five consecutive bytes into one 40-bit word. Byte 0 lands in bits [7:0], byte 4 in bits [39:32].
- Pulses Rx_Done when a full word is available.
- Sits between the board RX pin and the application logic that consumes 40-bit commands/samples.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OSR, 16, oversampling ticks per bit
TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one word (used only with UART_RX_TIMEOUT_EN)

Ports:
Clk  input  1  system clock; one clock, all logic on rising edge
Reset  input  1  asynchronous, active-high reset
uart_rx  input  1  serial line; idle high; asynchronous to Clk
Data40  output  40  last completely received word
Rx_Done  output  1  one-cycle pulse: Data40 just updated
Rx_Busy  output  1  high while a word is partially assembled (byte count 1..4) or a byte is in flight
Frame_Err  output  1  one-cycle pulse: stop bit sampled low; byte dropped
Timeout_Err  output  1  one-cycle pulse: inter-byte timeout fired; tied 0 without macro

Behaviour:
- Reset: Data40=0, Rx_Done=0, Rx_Busy=0, Frame_Err=0, Timeout_Err=0. The byte-receiver FSM goes to IDLE and the byte count goes to 0. Reset mid-frame discards partial data.
- Input path: uart_rx passes through a 2-FF synchroniser. Falling-edge detection runs on the synchronised signal.
- Tick generator: TICK_DIV = CLK_HZ/(BAUD*OSR), integer truncation (27 at defaults). It produces a one-cycle tick and is restarted on start-edge detection.
- Byte receiver FSM:
  - IDLE: on a falling edge, go to START.
  - START: at tick 7, 8 and 9, take samples. The bit value is the majority of the three. If the majority is 1, treat it as a false start and return to IDLE. Otherwise go to DATA at tick 15.
  - DATA: 8 bits, LSB first, each bit decided by the same 3-sample majority. Go to STOP after bit 7.
  - STOP: decide at tick 9 of the stop bit, then return to IDLE immediately so that back-to-back bytes are accepted.
    - Stop bit = 1: byte_valid pulses for 1 cycle.
    - Stop bit = 0: Frame_Err pulses for 1 cycle.
- Assembler:
  - Holds the shadow register and the byte count k (0..4).
  - On byte_valid, the byte is written to shadow[8k+7:8k] and k is incremented.
  - When k==4 and byte_valid, Data40 takes {byte, shadow[31:0]}, Rx_Done pulses on the following cycle, and k returns to 0.
  - Data40 changes only at word completion; partial words are never visible.
- Frame_Err clears k to 0, so the partial word is discarded. This takes precedence over byte_valid; the two cannot coincide by construction.
- Latency: Rx_Done rises 2 Clk after the stop-bit decision tick of byte 4, excluding the synchroniser.
- Rx_Busy = (k!=0) or (FSM != IDLE).

Optional Feature:
- Macro UART_RX_TIMEOUT_EN.
- Defined:
  - A counter runs in ticks while k!=0 and the FSM is IDLE.
  - It clears on every start edge.
  - When it reaches TIMEOUT_BITS*OSR, k returns to 0 and Timeout_Err pulses for 1 cycle.
  - Data40 is unchanged.
  - If the timeout and a start edge occur in the same cycle, the start edge wins: no timeout.
- Undefined: no counter; a partial word waits indefinitely; Timeout_Err is driven constant 0.

Decomposition:
- Package uart_pkg:
  - Frame constants: DATA_BITS=8, BYTES_PER_WORD=5.
  - OSR sample indices: 7, 8, 9.
  - Enum for byte-FSM states: IDLE, START, DATA, STOP.
  - Function computing TICK_DIV from CLK_HZ, BAUD, OSR.
- One sub-module: uart_byte_rx, containing the synchroniser, tick generator, byte FSM and Frame_Err.
  - Interface: Clk, Reset, uart_rx, byte_data[7:0], byte_valid, frame_err, start_edge, idle.
  - Top level: assembler, plus the timeout when enabled.

Test Plan (defaults; 1 bit = 432 Clk):
1. Send bytes 0x11,0x22,0x33,0x44,0x55 back-to-back -> single Rx_Done pulse, Data40=40'h5544332211, Frame_Err=0, Rx_Busy low afterwards.
2. 3-Clk low glitch on idle line, then a valid word 0xA5,0x00,0xFF,0x5A,0x3C -> no false byte; Data40=40'h3C5AFF00A5.
3. Byte 2 sent with stop bit 0 -> Frame_Err pulse, k=0. Then 5 good bytes 0x01..0x05 -> Data40=40'h0504030201, exactly one Rx_Done.
4. Assert Reset after 2 bytes, release, send 0x10..0x50 -> Data40=40'h5040302010; Data40 read 0 before completion.
5. (UART_RX_TIMEOUT_EN) 2 bytes, then idle 25 bit-times, then 5 bytes 0xAA..0xEE -> Timeout_Err pulse at 20 bit-times, Data40=40'hEEDDCCBBAA. Without macro: Timeout_Err stays 0; first 2 bytes are used as bytes 0-1 and Rx_Done fires after the 3rd new byte.
6. Sender at BAUD+2% and BAUD-2%, word 0x0F0F0F0F0F -> correct Data40, no Frame_Err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, byte-FSM state type and baud-tick helper
// for the 5-byte UART receive link.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 5;

  // oversample ticks used for the 3-sample majority vote
  localparam int SMP_A = 7;
  localparam int SMP_B = 8;
  localparam int SMP_C = 9;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // clocks per oversample tick, truncated, never below 1
  function automatic int tick_div(
    input int clk_hz,
    input int baud,
    input int osr
  );
    int d;
    d = clk_hz / (baud * osr);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchroniser, oversample tick generator,
// byte FSM with 3-sample majority voting and framing check.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int OSR    = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       start_edge,
  output logic       idle
);

  localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OSR);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OSR_W    = $clog2(OSR);

  logic             rx_m_q;
  logic             rx_s_q;
  logic             rx_p_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  rx_state_e        state_q, state_d;
  logic [OSR_W-1:0] tidx_q, tidx_d;
  logic [1:0]       smp_q, smp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             bv_q, bv_d;
  logic             fe_q, fe_d;
  logic             fall;
  logic             maj;
  logic             smp_en;
  logic             at_c;
  logic             at_end;

  // two-flop synchroniser plus one flop of history for edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= uart_rx;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  assign fall       = rx_p_q & ~rx_s_q;
  assign idle       = (state_q == IDLE);
  assign start_edge = fall & idle;

  assign tick   = (div_q == DIV_W'(TICK_DIV - 1));
  assign smp_en = tick & ((tidx_q == OSR_W'(SMP_A)) |
                          (tidx_q == OSR_W'(SMP_B)));
  assign at_c   = tick & (tidx_q == OSR_W'(SMP_C));
  assign at_end = tick & (tidx_q == OSR_W'(OSR - 1));

  assign maj = (smp_q[1] & smp_q[0]) |
               (smp_q[1] & rx_s_q)   |
               (smp_q[0] & rx_s_q);

  // tick divider, re-phased on every accepted start edge
  always_comb begin
    div_d = div_q + 1'b1;
    if (start_edge || tick) div_d = '0;
  end

  // tick divider register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) div_q <= '0;
    else       div_q <= div_d;
  end

  // byte FSM next-state and datapath
  always_comb begin
    state_d = state_q;
    tidx_d  = tidx_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    if (tick) begin
      if (tidx_q == OSR_W'(OSR - 1)) tidx_d = '0;
      else                           tidx_d = tidx_q + 1'b1;
    end
    if (smp_en) smp_d = {smp_q[0], rx_s_q};
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          tidx_d  = '0;
        end
      end
      START: begin
        if (at_c && maj) begin
          state_d = IDLE;
        end else if (at_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (at_c) sh_d = {maj, sh_q[7:1]};
        if (at_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
          else                            bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (at_c) begin
          state_d = IDLE;
          bv_d    = maj;
          fe_d    = ~maj;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // byte FSM state and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      tidx_q  <= '0;
      smp_q   <= 2'b11;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tidx_q  <= tidx_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  assign byte_data  = sh_q;
  assign byte_valid = bv_q;
  assign frame_err  = fe_q;

endmodule

// File: rtl/uart_rx_data40.sv
// 5-byte UART word receiver: assembles bytes into a 40-bit word.
// Optional inter-byte timeout enabled by UART_RX_TIMEOUT_EN.
module uart_rx_data40
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int OSR          = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        uart_rx,
  output logic [39:0] Data40,
  output logic        Rx_Done,
  output logic        Rx_Busy,
  output logic        Frame_Err,
  output logic        Timeout_Err
);

  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_err;
  logic        start_edge;
  logic        idle;
  logic [2:0]  k_q, k_d;
  logic [31:0] sh_q, sh_d;
  logic [39:0] data_q, data_d;
  logic        done_q, done_d;
  logic        to_q, to_d;
  logic        to_fire;

  uart_byte_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OSR    (OSR)
  ) u_byte (
    .Clk        (Clk),
    .Reset      (Reset),
    .uart_rx    (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .start_edge (start_edge),
    .idle       (idle)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OSR);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TO_LIM   = TIMEOUT_BITS * OSR;
  localparam int TO_W     = $clog2(TO_LIM + 1);

  logic [DIV_W-1:0] tdiv_q;
  logic             tick;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  assign tick = (tdiv_q == DIV_W'(TICK_DIV - 1));

  // local tick divider, phase-aligned with the byte receiver
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                    tdiv_q <= '0;
    else if (start_edge || tick)  tdiv_q <= '0;
    else                          tdiv_q <= tdiv_q + 1'b1;
  end

  // idle-gap counter; a start edge always beats the timeout
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_fire  = 1'b0;
    if (start_edge || k_q == '0) begin
      to_cnt_d = '0;
    end else if (idle && tick) begin
      if (to_cnt_q == TO_W'(TO_LIM - 1)) begin
        to_fire  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // idle-gap counter register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_cfg;

  assign to_fire    = 1'b0;
  assign unused_cfg = start_edge & (TIMEOUT_BITS != 0);
`endif

  // word assembler: shadow fill, publish on fifth byte, abort paths
  always_comb begin
    k_d    = k_q;
    sh_d   = sh_q;
    data_d = data_q;
    done_d = 1'b0;
    to_d   = 1'b0;
    if (byte_valid) begin
      if (k_q == 3'(BYTES_PER_WORD - 1)) begin
        data_d = {byte_data, sh_q};
        done_d = 1'b1;
        k_d    = '0;
      end else begin
        sh_d[{k_q[1:0], 3'b000} +: 8] = byte_data;
        k_d = k_q + 1'b1;
      end
    end else if (to_fire) begin
      k_d  = '0;
      to_d = 1'b1;
    end
    if (frame_err) k_d = '0;
  end

  // assembler registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      k_q    <= '0;
      sh_q   <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      k_q    <= k_d;
      sh_q   <= sh_d;
      data_q <= data_d;
      done_q <= done_d;
      to_q   <= to_d;
    end
  end

  assign Data40      = data_q;
  assign Rx_Done     = done_q;
  assign Rx_Busy     = (k_q != '0) | ~idle;
  assign Frame_Err   = frame_err;
  assign Timeout_Err = to_q;

endmodule
